// File: rtl/sprite_blit_engine.sv
// Sprite blitter: walks a W x H sprite from a registered ROM in raster order and writes
// opaque, on-screen pixels to the frame buffer at the latched sprite origin.
module sprite_blit_engine #(
    parameter int          W           = 32,
    parameter int          H           = 32,
    parameter int          SCREEN_W    = 640,
    parameter int          SCREEN_H    = 480,
    parameter logic [7:0]  TRANSPARENT = 8'h00
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [9:0]  sprite_x,
    input  logic [9:0]  sprite_y,
    output logic        busy,
    output logic        done,
    output logic [15:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [7:0]  fb_data,
    input  logic        fb_ready
);

    // state | meaning
    // IDLE  | waiting for start
    // PRIME | address 0 in flight to the ROM
    // DRAW  | pixel px_q/py_q presented, next address already issued
    // FIN   | one-cycle done pulse
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_DRAW, S_FIN} state_t;

    state_t      state_q;
    logic [9:0]  x_q, y_q;
    logic [9:0]  px_q, py_q;
    logic [15:0] rom_addr_q;
    logic        busy_q, done_q;
    logic [7:0]  cap_q;
    logic        cap_valid_q;

    logic [10:0] x_sum, y_sum;
    logic [7:0]  pix_data;
    logic        on_screen, pix_we, retire, last_pix;
    logic [18:0] pix_addr;

    assign x_sum     = {1'b0, x_q} + {1'b0, px_q};
    assign y_sum     = {1'b0, y_q} + {1'b0, py_q};
    // The ROM moves on to k+1 while a stalled pixel waits, so its data is kept locally.
    assign pix_data  = cap_valid_q ? cap_q : rom_data;
    assign on_screen = (x_sum < 11'(SCREEN_W)) && (y_sum < 11'(SCREEN_H));
    assign pix_we    = (state_q == S_DRAW) && on_screen && (pix_data != TRANSPARENT);
    assign pix_addr  = 19'(y_sum) * 19'(SCREEN_W) + 19'(x_sum);
    assign retire    = (state_q == S_DRAW) && (!pix_we || fb_ready);
    assign last_pix  = (px_q == 10'(W - 1)) && (py_q == 10'(H - 1));

    assign fb_we    = pix_we;
    assign fb_addr  = pix_we ? pix_addr : '0;
    assign fb_data  = pix_we ? pix_data : '0;
    assign rom_addr = rom_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            px_q        <= '0;
            py_q        <= '0;
            rom_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cap_q       <= '0;
            cap_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        x_q         <= sprite_x;
                        y_q         <= sprite_y;
                        px_q        <= '0;
                        py_q        <= '0;
                        rom_addr_q  <= '0;
                        cap_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    rom_addr_q <= 16'd1;
                    state_q    <= S_DRAW;
                end
                S_DRAW: begin
                    if (retire) begin
                        cap_valid_q <= 1'b0;
                        rom_addr_q  <= rom_addr_q + 16'd1;
                        if (last_pix) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else if (px_q == 10'(W - 1)) begin
                            px_q <= '0;
                            py_q <= py_q + 10'd1;
                        end else begin
                            px_q <= px_q + 10'd1;
                        end
                    end else if (!cap_valid_q) begin
                        cap_q       <= rom_data;
                        cap_valid_q <= 1'b1;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blit_engine.sv
// Scoreboard bench for sprite_blit_engine: a sprite/clipping model queues the expected
// frame-buffer writes; a monitor pops and compares them on every accepted write.
module tb_sprite_blit_engine;

    logic        Clk = 1'b0;
    logic        Reset_n, start, fb_ready;
    logic [9:0]  sprite_x, sprite_y;
    logic        busy, done, fb_we;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;

    sprite_blit_engine dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start),
        .sprite_x(sprite_x), .sprite_y(sprite_y),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_ready(fb_ready)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [1024];
    always @(posedge Clk) rom_data <= mem[rom_addr[9:0]];

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int nwr, first_addr, last_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected write per accepted frame-buffer write.
    initial begin
        bit          prev_stall;
        logic [18:0] prev_addr;
        logic [7:0]  prev_data;
        wr_t         w;
        prev_stall = 0;
        prev_addr  = '0;
        prev_data  = '0;
        forever begin
            @(negedge Clk);
            if (Reset_n !== 1'b1) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_we", fb_we, 1);
                chk("stall_addr", fb_addr, prev_addr);
                chk("stall_data", fb_data, prev_data);
            end
            if (fb_we === 1'b1) begin
                chk("fb_addr_range", fb_addr <= 19'd307199, 1);
                if (fb_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", fb_addr, 32'hFFFF_FFFF);
                    end else begin
                        w = exp_q.pop_front();
                        chk("wr_addr", fb_addr, w.addr);
                        chk("wr_data", fb_data, w.data);
                    end
                    nwr++;
                    if (nwr == 1) first_addr = fb_addr;
                    last_addr = fb_addr;
                end
            end
            prev_stall = (fb_we === 1'b1) && !fb_ready;
            prev_addr  = fb_addr;
            prev_data  = fb_data;
        end
    end

    // mode: 0 fb_ready always 1, 1 random fb_ready, 2 fb_ready low 5 cycles on pixel 40
    task automatic run_draw(input int x, input int y, input int mode, input int exp_writes,
                            input bit poke, input int rst_at);
        int  n, done_n;
        exp_q.delete();
        for (int py = 0; py < 32; py++)
            for (int px = 0; px < 32; px++)
                if (mem[py*32+px] != 8'h00 && x + px < 640 && y + py < 480)
                    exp_q.push_back(wr_t'{addr: (y+py)*640 + (x+px), data: mem[py*32+px]});
        nwr = 0;
        @(posedge Clk); #1;
        sprite_x = 10'(x);
        sprite_y = 10'(y);
        fb_ready = 1'b1;
        start    = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("prime_rom_addr", rom_addr, 0);
        if (poke) begin
            sprite_x = 10'd3;
            sprite_y = 10'd7;
        end
        n      = 1;
        done_n = 0;
        while (n < 4000) begin
            case (mode)
                1:       fb_ready = ($urandom_range(0, 3) != 0);
                2:       fb_ready = !(n >= 42 && n <= 46);
                default: fb_ready = 1'b1;
            endcase
            if (rst_at >= 0 && n == rst_at) begin
                #2 Reset_n = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_fb_we", fb_we, 0);
                chk("rst_fb_addr", fb_addr, 0);
                chk("rst_fb_data", fb_data, 0);
                chk("rst_rom_addr", rom_addr, 0);
                chk("rst_writes_before", nwr, rst_at - 2);
                exp_q.delete();
                repeat (3) begin
                    @(posedge Clk); #1;
                    chk("rst_hold_done", done, 0);
                    chk("rst_hold_busy", busy, 0);
                end
                Reset_n = 1'b1;
                fb_ready = 1'b1;
                return;
            end
            if (done === 1'b1) begin
                done_n = n;
                break;
            end
            start = (poke && n == 500);
            @(posedge Clk); #1;
            n++;
        end
        start    = 1'b0;
        fb_ready = 1'b1;
        if (done_n == 0) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("busy_at_done", busy, 0);
        if (mode == 0) chk("done_cycle", done_n, 1026);
        if (mode == 2) chk("done_cycle_stall", done_n, 1031);
        chk("writes_left", exp_q.size(), 0);
        if (exp_writes >= 0) chk("write_count", nwr, exp_writes);
        if (poke) start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        @(posedge Clk); #1;
        chk("idle_busy2", busy, 0);
    endtask

    initial begin
        Reset_n  = 1'b0;
        start    = 1'b0;
        fb_ready = 1'b1;
        sprite_x = '0;
        sprite_y = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        #12;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_fb_we", fb_we, 0);
        chk("reset_rom_addr", rom_addr, 0);
        chk("reset_fb_addr", fb_addr, 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h1F;
        run_draw(100, 50, 0, 1024, 0, -1);
        chk("first_fb_addr", first_addr, 32100);
        chk("last_fb_addr", last_addr, 51971);

        for (int i = 0; i < 1024; i++) mem[i] = (((i % 32) + (i / 32)) % 2 == 1) ? 8'h3C : 8'h00;
        run_draw(100, 50, 0, 512, 0, -1);

        for (int i = 0; i < 1024; i++) mem[i] = 8'hA5;
        run_draw(620, 470, 0, 200, 0, -1);

        for (int i = 0; i < 1024; i++) mem[i] = 8'h1F;
        run_draw(10, 20, 2, 1024, 0, -1);

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 255));
        run_draw(200, 100, 0, -1, 1, -1);

        for (int i = 0; i < 1024; i++) mem[i] = 8'h1F;
        run_draw(0, 0, 0, -1, 0, 302);
        run_draw(5, 5, 0, 1024, 0, -1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 1024; i++)
                mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            run_draw(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)), 1, -1, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
